// File: rtl/ser_tx_ctrl.sv
// ser_tx_ctrl
// Transmit-side sequencer for a WORD_W-bit PISO serializer. After tx_en it
// loads SYNC_WORDS comma words, then encoded data words. It fills any data gap
// with IDLE_WORD. There is one load slot every WORD_W clocks, and each load
// reaches the PISO as a one-cycle load_en/par_out pair.
// Optional feature macro: TX_PRBS_EN adds a PRBS7 (x^7+x^6+1) test source.
// The source is selected by prbs_mode in DATA.
module ser_tx_ctrl #(
    parameter int                WORD_W     = 10,
    parameter logic [WORD_W-1:0] COMMA_WORD = 10'b0101111100,
    parameter logic [WORD_W-1:0] IDLE_WORD  = 10'b1010000011,
    parameter int                SYNC_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              prbs_mode,
    output logic [WORD_W-1:0] par_out,
    output logic              load_en,
    output logic              sync_done,
    output logic              underrun
);

    localparam int                CNT_W     = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORD_W - 1);
    localparam logic [7:0]        SYNC_LAST = 8'(SYNC_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         sync_cnt_q, sync_cnt_d;
    logic               first_q, first_d;
    logic               load_d, under_d;
    logic [WORD_W-1:0]  par_d;
    logic               slot;
    logic               prbs_sel;

`ifdef TX_PRBS_EN
    logic [6:0]         lfsr_q, lfsr_d;
    logic [6:0]         prbs_state;
    logic [WORD_W-1:0]  prbs_word;

    assign prbs_sel = prbs_mode;

    // Unroll WORD_W LFSR steps; bit 0 of the word is the first bit generated.
    always_comb begin
        prbs_state = lfsr_q;
        prbs_word  = '0;
        for (int i = 0; i < WORD_W; i++) begin
            prbs_word[i] = prbs_state[6] ^ prbs_state[5];
            prbs_state   = {prbs_state[5:0], prbs_word[i]};
        end
    end

    // PRBS7 state; it advances only when a PRBS word is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 7'h7F;
        else        lfsr_q <= lfsr_d;
    end
`else
    logic unused_prbs_mode;
    assign unused_prbs_mode = prbs_mode;
    assign prbs_sel = 1'b0;
`endif

    // A slot is the last bit of the current word, or the first cycle after IDLE.
    assign slot = (state_q != S_IDLE) && (first_q || (bit_cnt_q == LAST_CNT));

    // Next state, counters and next values of the registered outputs.
    // Handshake: in_data is taken on a cycle where in_valid && in_ready.
    // in_ready is high only on a DATA slot with tx_en=1 and no PRBS source.
    // It never depends on in_valid, and the word is not held past that cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        first_d    = 1'b0;
        load_d     = 1'b0;
        par_d      = '0;
        under_d    = 1'b0;
        in_ready   = 1'b0;
`ifdef TX_PRBS_EN
        lfsr_d     = lfsr_q;
`endif
        case (state_q)
            S_IDLE: begin
                bit_cnt_d  = '0;
                sync_cnt_d = '0;
                if (tx_en) begin
                    state_d = S_SYNC;
                    first_d = 1'b1;
                end
            end
            S_SYNC: begin
                bit_cnt_d = slot ? '0 : bit_cnt_q + CNT_W'(1);
                if (slot) begin
                    if (!tx_en) begin
                        state_d = S_IDLE;
                    end else begin
                        load_d = 1'b1;
                        par_d  = COMMA_WORD;
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_d    = S_DATA;
                            sync_cnt_d = '0;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_DATA: begin
                bit_cnt_d = slot ? '0 : bit_cnt_q + CNT_W'(1);
                in_ready  = slot && tx_en && !prbs_sel;
                if (slot) begin
                    if (!tx_en) begin
                        state_d = S_IDLE;
                    end else begin
                        load_d = 1'b1;
`ifdef TX_PRBS_EN
                        if (prbs_sel) begin
                            par_d  = prbs_word;
                            lfsr_d = prbs_state;
                        end else
`endif
                        if (in_valid) begin
                            par_d = in_data;
                        end else begin
                            par_d   = IDLE_WORD;
                            under_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            first_q    <= 1'b0;
            load_en    <= 1'b0;
            par_out    <= '0;
            underrun   <= 1'b0;
            sync_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            first_q    <= first_d;
            load_en    <= load_d;
            par_out    <= par_d;
            underrun   <= under_d;
            sync_done  <= (state_d == S_DATA);
        end
    end

endmodule

// File: tb/tb_ser_tx_ctrl.sv
// Bench for ser_tx_ctrl: per-word vector table plus hand sequences covering
// tx_en drop, restart and asynchronous reset.
module tb_ser_tx_ctrl;
  localparam int W = 10;

  logic         clk, rst_n, tx_en, in_valid, in_ready, prbs_mode;
  logic         load_en, sync_done, underrun;
  logic [W-1:0] in_data, par_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         tx;
    logic         valid;
    logic [W-1:0] data;
    logic [W-1:0] exp_par;
    logic         exp_under;
    logic         exp_sd;
    int           exp_ready;
    int           exp_gap;
  } vec_t;

  vec_t vecs[9];
  logic [6:0] model_lfsr;

  ser_tx_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prbs_mode (prbs_mode),
    .par_out   (par_out),
    .load_en   (load_en),
    .sync_done (sync_done),
    .underrun  (underrun)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one word's inputs, then wait (bounded) for its load and check it.
  task automatic run_vec(input vec_t v, input string tag);
    int  gap;
    int  ready_cnt;
    bit  seen;
    gap = 0;
    ready_cnt = 0;
    seen = 1'b0;
    tx_en = v.tx;
    in_valid = v.valid;
    in_data = v.data;
    for (int g = 1; g <= 12 && !seen; g++) begin
      @(negedge clk);
      if (in_ready) ready_cnt++;
      if (load_en) begin
        seen = 1'b1;
        gap = g;
      end else begin
        chk({tag, " par_out between loads"}, 32'(par_out), 32'd0);
        chk({tag, " underrun between loads"}, 32'(underrun), 32'd0);
      end
    end
    chk({tag, " load_en seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, " load gap"}, 32'(gap), 32'(v.exp_gap));
      chk({tag, " par_out"}, 32'(par_out), 32'(v.exp_par));
      chk({tag, " underrun"}, 32'(underrun), 32'(v.exp_under));
      chk({tag, " sync_done"}, 32'(sync_done), 32'(v.exp_sd));
      chk({tag, " accepts"}, 32'(ready_cnt), 32'(v.exp_ready));
    end
  endtask

  // Drop tx_en at bit_cnt=3 of the word just loaded; expect no more loads or accepts.
  task automatic drop_tx(input string tag);
    repeat (3) @(negedge clk);
    tx_en = 1'b0;
    in_valid = 1'b1;
    in_data = 10'h2AA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk({tag, " no load after drop"}, 32'(load_en), 32'd0);
      chk({tag, " no ready after drop"}, 32'(in_ready), 32'd0);
    end
    chk({tag, " sync_done after drop"}, 32'(sync_done), 32'd0);
  endtask

  function automatic logic [W-1:0] model_prbs_word();
    logic [W-1:0] w;
    logic         nb;
    w = '0;
    for (int i = 0; i < W; i++) begin
      nb = model_lfsr[6] ^ model_lfsr[5];
      w[i] = nb;
      model_lfsr = {model_lfsr[5:0], nb};
    end
    return w;
  endfunction

  initial begin
    vec_t pv;
    //             tx    valid  data    exp_par  und   sd    rdy gap
    vecs[0] = '{1'b1, 1'b1, 10'h3FF, 10'h17C, 1'b0, 1'b0, 0,  2};
    vecs[1] = '{1'b1, 1'b1, 10'h3FF, 10'h17C, 1'b0, 1'b0, 0, 10};
    vecs[2] = '{1'b1, 1'b0, 10'h000, 10'h17C, 1'b0, 1'b0, 0, 10};
    vecs[3] = '{1'b1, 1'b1, 10'h3FF, 10'h17C, 1'b0, 1'b1, 0, 10};
    vecs[4] = '{1'b1, 1'b1, 10'h001, 10'h001, 1'b0, 1'b1, 1, 10};
    vecs[5] = '{1'b1, 1'b1, 10'h002, 10'h002, 1'b0, 1'b1, 1, 10};
    vecs[6] = '{1'b1, 1'b1, 10'h003, 10'h003, 1'b0, 1'b1, 1, 10};
    vecs[7] = '{1'b1, 1'b0, 10'h000, 10'h283, 1'b1, 1'b1, 1, 10};
    vecs[8] = '{1'b1, 1'b1, 10'h155, 10'h155, 1'b0, 1'b1, 1, 10};

    // reset
    rst_n = 1'b0;
    tx_en = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    prbs_mode = 1'b0;
    model_lfsr = 7'h7F;
    #2;
    chk("reset load_en", 32'(load_en), 32'd0);
    chk("reset par_out", 32'(par_out), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset sync_done", 32'(sync_done), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle no load", 32'(load_en), 32'd0);
    end

    // preamble then data, underrun
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("run1 v%0d", i));

    // tx_en drop at bit_cnt=3, then full restart
    drop_tx("drop1");
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("restart v%0d", i));

    // drop again, then reset mid-preamble on the 2nd comma load
    drop_tx("drop2");
    run_vec(vecs[0], "pre-reset v0");
    run_vec(vecs[1], "pre-reset v1");
    rst_n = 1'b0;
    #1;
    chk("async reset load_en", 32'(load_en), 32'd0);
    chk("async reset par_out", 32'(par_out), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd0);
    chk("async reset sync_done", 32'(sync_done), 32'd0);
    chk("async reset underrun", 32'(underrun), 32'd0);
    tx_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post-reset no load", 32'(load_en), 32'd0);
    end
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("run2 v%0d", i));

    // prbs_mode=1 in DATA
    prbs_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pv = '{1'b1, 1'b1, W'(10'h0AA + i), W'(10'h0AA + i), 1'b0, 1'b1, 1, 10};
`ifdef TX_PRBS_EN
      pv.exp_par = model_prbs_word();
      pv.exp_ready = 0;
`endif
      run_vec(pv, $sformatf("prbs w%0d", i));
    end
    prbs_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
